// File: rtl/pll_lock_supervisor_pkg.sv
// pll_lock_supervisor_pkg: state encoding and timer sizing shared by the PLL supervisor
package pll_lock_supervisor_pkg;
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;
  function automatic int tmr_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/pll_lock_supervisor_sync_bit.sv
// sync_bit: flop chain bringing an asynchronous level into the clk domain
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_q;
  always_ff @(posedge clk) begin
    if (rst) r_q <= '0;
    else begin
      r_q[0] <= i_d;
      for (int k = 1; k < STAGES; k++) r_q[k] <= r_q[k-1];
    end
  end
  assign o_q = r_q[STAGES-1];
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset/lock on the reference clock and gates the system reset
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int PLL_RESET_CYCLES   = 16,
  parameter int LOCK_TIMEOUT       = 12000,
  parameter int LOCK_STABLE_CYCLES = 1200,
  parameter int LOSS_FILTER        = 4,
  parameter int MAX_RETRIES        = 3,
  parameter int CNT_W              = 8
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             locked,
  input  logic             restart_req,
  output logic             pll_resetb,
  output logic             sys_reset,
  output logic             ready,
  output logic             fail,
  output logic [3:0]       retry_count,
  output logic [CNT_W-1:0] loss_count,
  output logic [2:0]       state
);
  localparam int TW = tmr_w(PLL_RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES);
  localparam int LW = (LOSS_FILTER < 2) ? 1 : $clog2(LOSS_FILTER);
  localparam logic [3:0] MAXR = 4'(MAX_RETRIES);
  state_t r_state, w_next;
  logic [TW-1:0] r_timer, w_timer;
  logic [LW-1:0] r_low, w_low;
  logic [3:0] w_retry;
  logic [CNT_W-1:0] w_loss;
  logic w_locked_s;
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clock_in),
    .rst (reset),
    .i_d (locked),
    .o_q (w_locked_s)
  );
  always_comb begin
    w_next  = r_state;
    w_retry = retry_count;
    w_loss  = loss_count;
    w_low   = '0;
    case (r_state)
      PLL_RST:   if (r_timer == TW'(PLL_RESET_CYCLES - 1)) w_next = WAIT_LOCK;
      WAIT_LOCK: begin
        if (w_locked_s) w_next = STABILIZE;
        else if (r_timer == TW'(LOCK_TIMEOUT - 1)) begin
          w_next  = (retry_count == MAXR) ? FAIL : PLL_RST;
          w_retry = (retry_count == MAXR) ? retry_count : retry_count + 4'd1;
        end
      end
      STABILIZE: begin
        if (!w_locked_s) w_next = WAIT_LOCK;
        else if (r_timer == TW'(LOCK_STABLE_CYCLES - 1)) begin
          w_next  = RUN;
          w_retry = '0;
        end
      end
      RUN: begin
        // short low runs are absorbed; the low counter restarts on every locked cycle
        if (!w_locked_s && r_low == LW'(LOSS_FILTER - 1)) begin
          w_next = PLL_RST;
          w_loss = &loss_count ? loss_count : loss_count + CNT_W'(1);
        end else if (!w_locked_s) w_low = r_low + LW'(1);
      end
      FAIL:      w_next = FAIL;
      default:   w_next = PLL_RST;
    endcase
    if (restart_req) begin
      w_next  = PLL_RST;
      w_retry = '0;
      w_loss  = loss_count;
      w_low   = '0;
    end
    // timers hold in RUN/FAIL so they can never wrap
    w_timer = (restart_req || w_next != r_state) ? '0 :
              (r_state == RUN || r_state == FAIL) ? r_timer : r_timer + TW'(1);
  end
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state     <= PLL_RST;
      r_timer     <= '0;
      r_low       <= '0;
      retry_count <= '0;
      loss_count  <= '0;
      pll_resetb  <= 1'b0;
      sys_reset   <= 1'b1;
      ready       <= 1'b0;
      fail        <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_timer     <= w_timer;
      r_low       <= w_low;
      retry_count <= w_retry;
      loss_count  <= w_loss;
      pll_resetb  <= !(w_next == PLL_RST || w_next == FAIL);
      sys_reset   <= w_next != RUN;
      ready       <= w_next == RUN;
      fail        <= w_next == FAIL;
    end
  end
  assign state = r_state;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed and random checks against a cycle-stamped behavioural model
module tb_pll_lock_supervisor;
  localparam int SS = 2, PRC = 4, LT = 20, LSC = 8, LF = 3, MR = 2, CW = 8;
  logic clk = 1'b0;
  logic reset = 1'b1, locked = 1'b0, restart_req = 1'b0;
  logic pll_resetb, sys_reset, ready, fail;
  logic [3:0] retry_count;
  logic [CW-1:0] loss_count;
  logic [2:0] state;
  int n_cmp = 0, n_err = 0, cyc = 0;
  int m_phase = 0, m_t0 = 0, m_retry = 0, m_loss = 0, m_low = 0, ecnt = 0;
  bit m_hist[$];

  pll_lock_supervisor #(
    .SYNC_STAGES(SS), .PLL_RESET_CYCLES(PRC), .LOCK_TIMEOUT(LT),
    .LOCK_STABLE_CYCLES(LSC), .LOSS_FILTER(LF), .MAX_RETRIES(MR), .CNT_W(CW)
  ) dut (
    .clock_in(clk), .reset(reset), .locked(locked), .restart_req(restart_req),
    .pll_resetb(pll_resetb), .sys_reset(sys_reset), .ready(ready), .fail(fail),
    .retry_count(retry_count), .loss_count(loss_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Phase numbers are the published state codes; time in phase is ecnt - m_t0.
  task automatic model_edge();
    bit ls;
    int np, el;
    if (reset) begin
      m_phase = 0; m_retry = 0; m_loss = 0; m_low = 0; m_t0 = ecnt + 1;
      m_hist.delete();
      for (int i = 0; i < SS; i++) m_hist.push_back(1'b0);
    end else begin
      ls = m_hist.pop_front();
      m_hist.push_back(locked);
      el = ecnt - m_t0;
      np = m_phase;
      if (restart_req) begin
        np = 0; m_retry = 0; m_low = 0; m_t0 = ecnt + 1;
      end else begin
        if (m_phase == 0 && el == PRC - 1) np = 1;
        else if (m_phase == 1) begin
          if (ls) np = 2;
          else if (el == LT - 1) begin
            if (m_retry == MR) np = 4;
            else begin np = 0; m_retry++; end
          end
        end else if (m_phase == 2) begin
          if (!ls) np = 1;
          else if (el == LSC - 1) begin np = 3; m_retry = 0; end
        end else if (m_phase == 3) begin
          m_low = ls ? 0 : m_low + 1;
          if (m_low == LF) begin np = 0; m_loss = (m_loss >= 255) ? 255 : m_loss + 1; end
        end
        if (np != m_phase) begin m_t0 = ecnt + 1; m_low = 0; end
      end
      m_phase = np;
    end
    ecnt++;
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_phase));
    chk("pll_resetb", 32'(pll_resetb), 32'(!(m_phase == 0 || m_phase == 4)));
    chk("sys_reset", 32'(sys_reset), 32'(m_phase != 3));
    chk("ready", 32'(ready), 32'(m_phase == 3));
    chk("fail", 32'(fail), 32'(m_phase == 4));
    chk("retry_count", 32'(retry_count), 32'(m_retry));
    chk("loss_count", 32'(loss_count), 32'(m_loss));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check_all();
    end
  endtask

  initial begin
    int run_left;
    // reset state
    tick(3);
    chk("rst_state", 32'(state), 0);
    chk("rst_pll_resetb", 32'(pll_resetb), 0);
    chk("rst_sys_reset", 32'(sys_reset), 1);
    chk("rst_loss", 32'(loss_count), 0);
    reset = 1'b0;
    cyc = 0;
    // normal start
    tick(3);
    chk("start_resetb_c3", 32'(pll_resetb), 0);
    tick(1);
    chk("start_resetb_c4", 32'(pll_resetb), 1);
    chk("start_wait_c4", 32'(state), 1);
    tick(6);
    locked = 1'b1;
    tick(10);
    chk("start_ready_c20", 32'(ready), 0);
    tick(1);
    chk("start_ready_c21", 32'(ready), 1);
    chk("start_sysrst_c21", 32'(sys_reset), 0);
    chk("start_retry_c21", 32'(retry_count), 0);
    // loss filter: short dip ignored
    tick(4);
    locked = 1'b0;
    tick(2);
    locked = 1'b1;
    tick(6);
    chk("dip_state", 32'(state), 3);
    chk("dip_loss", 32'(loss_count), 0);
    // loss filter: full dip
    locked = 1'b0;
    tick(4);
    chk("loss_run_L4", 32'(state), 3);
    tick(1);
    chk("loss_state", 32'(state), 0);
    chk("loss_count1", 32'(loss_count), 1);
    chk("loss_sysrst", 32'(sys_reset), 1);
    chk("loss_ready", 32'(ready), 0);
    tick(3);
    chk("loss_resetb_L8", 32'(pll_resetb), 0);
    tick(1);
    chk("loss_resetb_L9", 32'(pll_resetb), 1);
    // glitch in STABILIZE
    tick(1);
    locked = 1'b1;
    tick(5);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(1);
    chk("glitch_stab", 32'(state), 2);
    tick(1);
    chk("glitch_back", 32'(state), 1);
    tick(1);
    chk("glitch_again", 32'(state), 2);
    tick(7);
    chk("glitch_ready_F10", 32'(ready), 0);
    tick(1);
    chk("glitch_ready_F11", 32'(ready), 1);
    // timeouts into FAIL
    locked = 1'b0;
    tick(5);
    chk("to_loss2", 32'(loss_count), 2);
    tick(23);
    chk("to_wait", 32'(state), 1);
    chk("to_retry0", 32'(retry_count), 0);
    tick(1);
    chk("to_retry1", 32'(retry_count), 1);
    chk("to_rst1", 32'(state), 0);
    tick(24);
    chk("to_retry2", 32'(retry_count), 2);
    tick(23);
    chk("to_wait3", 32'(state), 1);
    tick(1);
    chk("to_fail_state", 32'(state), 4);
    chk("to_fail", 32'(fail), 1);
    chk("to_fail_resetb", 32'(pll_resetb), 0);
    tick(100);
    chk("fail_hold", 32'(fail), 1);
    // restart from FAIL
    restart_req = 1'b1;
    locked = 1'b1;
    tick(1);
    restart_req = 1'b0;
    chk("rs_state", 32'(state), 0);
    chk("rs_fail", 32'(fail), 0);
    chk("rs_retry", 32'(retry_count), 0);
    chk("rs_loss", 32'(loss_count), 2);
    tick(12);
    chk("rs_ready_13", 32'(ready), 0);
    tick(1);
    chk("rs_ready_14", 32'(ready), 1);
    // random lock activity with occasional restart/reset
    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        locked = ~locked;
        run_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 40));
      end
      run_left--;
      restart_req = ($urandom_range(0, 199) == 0);
      reset = ($urandom_range(0, 699) == 0);
      tick(1);
    end
    restart_req = 1'b0;
    // saturation of loss_count
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    locked = 1'b1;
    tick(30);
    for (int i = 0; i < 270; i++) begin
      locked = 1'b0;
      tick(4);
      locked = 1'b1;
      tick(20);
      if (i == 253) chk("sat_254", 32'(loss_count), 254);
    end
    chk("sat_255", 32'(loss_count), 255);
    chk("sat_run", 32'(state), 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
